moore_sequence_generator: RTL

//  Transmit-side partner of the Moore 1001 sequence detector.
//  - Serialises a programmable PAT_W-bit pattern MSB-first onto a single-bit line.
//  - Repeats the pattern a programmed number of times, with an optional idle gap between repetitions.
//  - Flags completion with a one-cycle done pulse.
//  - Drives detector benches and acts as the stimulus source on the serial test path.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_piso_shift.sv | 30 +++
 rtl/moore_sequence_generator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the Moore 1001 serial test path: state encoding and the
// default pattern that the sequence generator and detector both use.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_SEND = 3'b001,
        S_GAP  = 3'b010,
        S_DONE = 3'b011
    } state_t;

    localparam logic [3:0] SEQ_PAT_DEF = 4'b1001;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in, serial-out shift register. The MSB is presented first and zeros
// fill in from the LSB side.
module seq_piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/moore_sequence_generator.sv
// Serialises a captured pattern MSB-first, repeating it with an optional idle gap,
// and pulses done after the last bit. All outputs decode from registered state.
module moore_sequence_generator
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(SEQ_PAT_DEF),
    parameter int               REP_W   = 4,
    parameter int               GAP_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep_in,
    input  logic [GAP_W-1:0] gap_in,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       present
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    state_t             state, next_state;
    logic [PAT_W-1:0]   pat_reg;
    logic [REP_W-1:0]   rep_cnt;
    logic [GAP_W-1:0]   gap_reg;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   bit_idx;

    logic               capture;
    logic               sr_load;
    logic               sr_shift;
    logic               rep_dec;
    logic               gap_load;
    logic               sr_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        rep_dec    = 1'b0;
        gap_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    capture    = 1'b1;
                    sr_load    = 1'b1;
                    next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (bit_idx == '0) begin
                    if (rep_cnt > REP_W'(1)) begin
                        rep_dec = 1'b1;
                        if (gap_reg != '0) begin
                            gap_load   = 1'b1;
                            next_state = S_GAP;
                        end else begin
                            sr_load = 1'b1;
                        end
                    end else begin
                        next_state = S_DONE;
                    end
                end else begin
                    sr_shift = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (gap_cnt == GAP_W'(1)) begin
                    sr_load    = 1'b1;
                    next_state = S_SEND;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Burst parameters are written only on an accepted start, so they hold steady
    // for the whole burst regardless of pat_in/rep_in/gap_in activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_reg <= PAT_DEF;
            rep_cnt <= '0;
            gap_reg <= '0;
            gap_cnt <= '0;
            bit_idx <= '0;
        end else begin
            if (capture) begin
                pat_reg <= pat_in;
                rep_cnt <= (rep_in == '0) ? REP_W'(1) : rep_in;
                gap_reg <= gap_in;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - REP_W'(1);
            end

            if (gap_load) begin
                gap_cnt <= gap_reg;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            if (sr_load) begin
                bit_idx <= IDX_W'(PAT_W - 1);
            end else if (sr_shift) begin
                bit_idx <= bit_idx - IDX_W'(1);
            end
        end
    end

    seq_piso_shift #(
        .W (PAT_W)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (capture ? pat_in : pat_reg),
        .msb   (sr_msb)
    );

    assign out_valid = (state == S_SEND);
    assign out       = out_valid & sr_msb;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign present   = state;

endmodule
